ram_sdp_pipe: RTL and testbench
===============================

Name: ram_sdp_pipe

Overview:
Parametrised simple dual-port RAM: one write port with per-lane byte enables, one read port with configurable read latency and a read-valid strobe. A built-in clear sequencer fills the whole array with a fixed value after reset, and again on request. Used as the general frame and line buffer primitive in the video and scan paths. The array itself is inferred block RAM; only the control and output registers are reset.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH.
LANE_WIDTH, 8, bits per byte-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
RD_LATENCY, 1, read latency in cycles; legal values are 1 and 2. Any other value is an elaboration error.
CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every address by the clear sequencer.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset_n  in  1  asynchronous active-low reset.
clear_req  in  1  one-cycle pulse; restarts the clear sweep; honoured only in READY.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  DATA_WIDTH  write data.
wr_be  in  NUM_LANES  lane enables; bit i controls data bits [i*LANE_WIDTH +: LANE_WIDTH].
rd_en  in  1  read strobe.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data; holds its last value when no read completes.
rd_valid  out  1  pulses high for one cycle for each accepted read, aligned with rd_data.
init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (reset_n low):
  - FSM goes to CLEAR and the clear address counter goes to 0.
  - init_busy=1, rd_valid=0, rd_data=0, and all pipeline valid bits are 0.
  - Array contents are not reset.
- FSM, two states:
  - CLEAR: each cycle, write CLEAR_VALUE to clr_addr and increment clr_addr.
  - CLEAR to READY: on the cycle that writes DEPTH-1. The sweep takes exactly DEPTH cycles after reset release. init_busy drops in the first READY cycle.
  - READY to CLEAR: on clear_req=1. clr_addr is reloaded to 0 and init_busy rises the next cycle.
  - clear_req during CLEAR is ignored; it does not restart the count.
- In CLEAR, user traffic is dropped:
  - wr_en is ignored and does not modify the array.
  - rd_en is ignored and generates no rd_valid.
  - A read accepted in READY that is still in the pipeline when CLEAR begins completes normally.
- Write (READY, wr_en=1): each lane with wr_be[i]=1 is updated at the clock edge; other lanes are unchanged. wr_en with wr_be=0 is a no-op.
- Read (READY, rd_en=1):
  - RD_LATENCY=1: rd_data is valid and rd_valid=1 in cycle N+1 for a request in cycle N.
  - RD_LATENCY=2: an extra output register is added, so data and valid appear in N+2.
  - Back-to-back reads are accepted every cycle at full throughput and with no stalls.
- Read-during-write to the same address in the same cycle: rd_data returns the OLD word (default build).
- Reads and writes to different addresses are fully independent.
- Address wrap: rd_addr and wr_addr are used modulo DEPTH. No out-of-range condition exists.
- Reset asserted mid-read: the pending valid is discarded and no rd_valid is produced after reset release.

Optional Feature:
RAM_SDP_PIPE_BYPASS_EN
- Defined: read-during-write to the same address returns NEW data, merged per lane.
  - Lanes with wr_be=1 take wr_data; other lanes take the stored word.
  - Implemented by a registered address compare and data/enable capture, plus a lane mux on the first read stage.
  - Applies at both RD_LATENCY values.
- Undefined: no bypass logic is built, and old-data behaviour applies as above.

Test Plan:
Bench configuration: DATA_WIDTH=16, ADDR_WIDTH=4, RD_LATENCY=1, CLEAR_VALUE=16'hA5A5.
1. Clear after reset: release reset -> init_busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 all return 16'hA5A5 with one rd_valid per read.
2. Byte enables: write 16'h1234 to address 3 with be=2'b11, then 16'hFFFF with be=2'b01. Read address 3 -> 16'h12FF.
3. Latency and throughput: reads of addresses 0,1,2 on consecutive cycles -> three consecutive rd_valid pulses, starting 1 cycle later with RD_LATENCY=1 and 2 cycles later with RD_LATENCY=2. Data returns in request order.
4. Read-during-write: address 5 holds 16'h0001; write 16'hBEEF with be=2'b11 while reading address 5 -> 16'h0001 in the default build, 16'hBEEF with RAM_SDP_PIPE_BYPASS_EN. A follow-up read returns 16'hBEEF in both builds.
5. Traffic during clear: in READY, pulse clear_req and write 16'h7777 to address 2 plus read address 2 during the sweep -> no rd_valid during the sweep. After init_busy falls, address 2 reads 16'hA5A5. A second clear_req mid-sweep does not extend the sweep beyond 16 cycles.
6. Reset mid-read: assert reset_n low in the cycle after rd_en -> rd_valid=0 and rd_data=0 during reset, and no stray rd_valid after release.

Source files
------------

// File: rtl/ram_sdp_pipe.sv
// ram_sdp_pipe: simple dual-port RAM with byte-lane writes, 1/2-cycle read pipeline and a clear sweep
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (control and output registers only)
//   clear_req  pulse in READY restarts the clear sweep
//   wr_en/wr_addr/wr_data/wr_be   write port with per-lane enables
//   rd_en/rd_addr                 read request
//   rd_data/rd_valid              read result, valid RD_LATENCY cycles after the request
//   init_busy  high while the clear sweep runs
//   Optional macro RAM_SDP_PIPE_BYPASS_EN: same-address read-during-write returns new data per lane.
module ram_sdp_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LANE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                clear_req,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]    wr_be,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_valid,
    output logic                                init_busy
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   clr_addr, clr_nx;
    logic                    rd_acc, wr_acc;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [NUM_LANES-1:0]    w_be;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_q, rd_s1;
    logic                    v1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_nx;
        end
    end

    // The sweep ends on the cycle that writes the last address, so it lasts exactly DEPTH cycles.
    always_comb begin
        state_nx = state;
        clr_nx   = clr_addr;
        if (state == CLEAR) begin
            clr_nx   = clr_addr + ADDR_WIDTH'(1);
            state_nx = (&clr_addr) ? READY : CLEAR;
        end else if (clear_req) begin
            clr_nx   = '0;
            state_nx = CLEAR;
        end
    end

    assign init_busy = (state == CLEAR);
    assign rd_acc    = rd_en && !init_busy;
    assign wr_acc    = wr_en && !init_busy;

    // The sweep owns the write port while clearing; user writes are dropped.
    always_comb begin
        w_addr = init_busy ? clr_addr : wr_addr;
        w_data = init_busy ? CLEAR_VALUE : wr_data;
        w_be   = init_busy ? {NUM_LANES{1'b1}} : (wr_acc ? wr_be : '0);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (w_be[i]) mem[w_addr][i*LANE_WIDTH +: LANE_WIDTH] <= w_data[i*LANE_WIDTH +: LANE_WIDTH];
    end

    // First read stage only loads on an accepted read, so rd_data holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            rd_q <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) rd_q <= mem[rd_addr];
        end
    end

`ifdef RAM_SDP_PIPE_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [NUM_LANES-1:0]  byp_be;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
            byp_be   <= '0;
        end else if (rd_acc) begin
            byp_hit  <= wr_acc && (wr_addr == rd_addr);
            byp_data <= wr_data;
            byp_be   <= wr_be;
        end
    end

    always_comb begin
        rd_s1 = rd_q;
        for (int i = 0; i < NUM_LANES; i++)
            if (byp_hit && byp_be[i]) rd_s1[i*LANE_WIDTH +: LANE_WIDTH] = byp_data[i*LANE_WIDTH +: LANE_WIDTH];
    end
`else
    assign rd_s1 = rd_q;
`endif

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] rd_o;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v2   <= 1'b0;
                rd_o <= '0;
            end else begin
                v2 <= v1;
                if (v1) rd_o <= rd_s1;
            end
        end
        assign rd_data  = rd_o;
        assign rd_valid = v2;
    end else if (RD_LATENCY == 1) begin : g_lat1
        assign rd_data  = rd_s1;
        assign rd_valid = v1;
    end else begin : g_bad
        $error("ram_sdp_pipe: RD_LATENCY must be 1 or 2");
        assign rd_data  = '0;
        assign rd_valid = 1'b0;
    end
endmodule

// File: tb/tb_ram_sdp_pipe.sv
// tb_ram_sdp_pipe: directed scoreboard bench for ram_sdp_pipe (16-bit words, 16 entries, latency 1)
module tb_ram_sdp_pipe;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        init_busy;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    logic [15:0] q[$];

    ram_sdp_pipe #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RD_LATENCY(1), .CLEAR_VALUE(16'hA5A5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && rd_valid) begin
            logic [15:0] e;
            rd_cnt++;
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL stray_valid got rd_valid=1 data=%h exp=no pending read", rd_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                assert (rd_data === e) else begin
                    bad++;
                    $error("FAIL rd_data got=%h exp=%h", rd_data, e);
                end
            end
        end
    end

    task automatic op(input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] be,
                      input logic re, input logic [3:0] ra, input logic push, input logic [15:0] exp);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (re && push) q.push_back(exp);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n;
        int c0;
        logic [15:0] rdw_exp;
        repeat (3) @(negedge clk);
        chk("reset_busy", init_busy, 1);
        chk("reset_valid", rd_valid, 0);
        chk("reset_data", rd_data, 0);

        // 1: clear sweep after reset
        reset_n = 1'b1;
        n = 0;
        while (init_busy && n < 100) begin n++; @(negedge clk); end
        chk("sweep_len_reset", n, 16);
        c0 = rd_cnt;
        for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a), 1, 16'hA5A5);
        drain();
        chk("clear_read_count", rd_cnt - c0, 16);

        // 2: byte enables
        op(1, 3, 16'h1234, 2'b11, 0, 0, 0, 0);
        op(1, 3, 16'hFFFF, 2'b01, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 3, 1, 16'h12FF);
        drain();
        op(1, 3, 16'hABCD, 2'b00, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 3, 1, 16'h12FF);
        drain();

        // 3: latency and back-to-back throughput, ordered data
        op(1, 0, 16'h0100, 2'b11, 0, 0, 0, 0);
        op(1, 1, 16'h0111, 2'b11, 0, 0, 0, 0);
        op(1, 2, 16'h0222, 2'b11, 0, 0, 0, 0);
        chk("lat_idle", rd_valid, 0);
        op(0, 0, 0, 0, 1, 0, 1, 16'h0100);
        chk("lat_v0", rd_valid, 1);
        op(0, 0, 0, 0, 1, 1, 1, 16'h0111);
        chk("lat_v1", rd_valid, 1);
        op(0, 0, 0, 0, 1, 2, 1, 16'h0222);
        chk("lat_v2", rd_valid, 1);
        @(negedge clk);
        chk("lat_end", rd_valid, 0);
        drain();

        // 4: read-during-write, then follow-up read
`ifdef RAM_SDP_PIPE_BYPASS_EN
        rdw_exp = 16'hBEEF;
`else
        rdw_exp = 16'h0001;
`endif
        op(1, 5, 16'h0001, 2'b11, 0, 0, 0, 0);
        op(1, 5, 16'hBEEF, 2'b11, 1, 5, 1, rdw_exp);
        op(0, 0, 0, 0, 1, 5, 1, 16'hBEEF);
        drain();

        // 5: traffic dropped during clear; second clear_req ignored
        c0 = rd_cnt;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (init_busy && n < 100) begin
            wr_en = (n == 12); wr_addr = 2; wr_data = 16'h7777; wr_be = 2'b11;
            rd_en = (n == 12 || n == 13); rd_addr = 2;
            clear_req = (n == 8);
            n++;
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
        chk("sweep_len_req", n, 16);
        @(negedge clk);
        chk("no_valid_in_clear", rd_cnt - c0, 0);
        op(0, 0, 0, 0, 1, 2, 1, 16'hA5A5);
        op(0, 0, 0, 0, 1, 0, 1, 16'hA5A5);
        drain();

        // 6: reset while a read is in flight
        op(1, 4, 16'h4444, 2'b11, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 4, 1, 16'h4444);
        drain();
        c0 = rd_cnt;
        rd_en = 1'b1; rd_addr = 4;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", rd_valid, 0);
        chk("rst_mid_data", rd_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (init_busy && n < 100) begin n++; @(negedge clk); end
        chk("sweep_len_rst2", n, 16);
        repeat (3) @(negedge clk);
        chk("no_stray_after_rst", rd_cnt - c0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
